// File: rtl/jtsdram_test_seq.sv
// jtsdram_test_seq: sequences BANKS SDRAM bank checkers through repeated test
// passes. Each pass waits for a frame tick, pulses start to the enabled banks,
// waits until all of them report done, then records their bad flags. A
// per-pass frame watchdog stops the sequence if a checker never finishes.
//
// Optional feature: define JTSDRAM_HALT_EN to halt the sequence after the
// first pass that reports a mismatch. The halt holds until rst.
module jtsdram_test_seq #(
    parameter int         BANKS = 4,
    parameter logic [7:0] TOUT  = 8'd60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             LVBL,
    input  logic             run,
    input  logic [BANKS-1:0] en,
    input  logic [BANKS-1:0] done,
    input  logic [BANKS-1:0] bad,
    output logic [BANKS-1:0] start,
    output logic             slow,
    output logic [BANKS-1:0] bad_bank,
    output logic [7:0]       pass_cnt,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_RUN,
        S_CHECK
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_lvbl;       // LVBL from the previous clock
    logic [BANKS-1:0] r_mask;       // banks taking part in the current pass
    logic [7:0]       r_frame_cnt;  // frame ticks seen in RUN this pass
    logic             r_first;      // first RUN cycle: checker done is stale

    logic             w_tick;
    logic             w_done_all;
    logic [7:0]       w_frame_next;
    logic             w_tout_hit;
    logic             w_halt_blk;   // IDLE may not re-arm
    logic             w_halt_now;   // this CHECK ends the sequence

    // Frame tick is a falling edge of LVBL against its registered copy.
    assign w_tick       = r_lvbl & ~LVBL;

    // Only masked banks count towards completion; the rest are don't-care.
    assign w_done_all   = ((done & r_mask) == r_mask);
    assign w_frame_next = r_frame_cnt + 8'd1;
    assign w_tout_hit   = w_tick && (w_frame_next >= TOUT);

`ifdef JTSDRAM_HALT_EN
    logic r_halt;
    logic w_bad_hit;

    assign w_bad_hit  = |(bad & r_mask);
    assign w_halt_blk = r_halt;
    assign w_halt_now = w_bad_hit;

    // Halt latch: set by a failing pass, cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halt <= 1'b0;
        end else if (r_state == S_CHECK && w_bad_hit) begin
            r_halt <= 1'b1;
        end
    end
`else
    assign w_halt_blk = 1'b0;
    assign w_halt_now = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through the case leaves w_next
        // unassigned, which would infer a latch.
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (run && !timeout && !w_halt_blk) begin
                    w_next = S_ARM;
                end
            end
            S_ARM: begin
                if (en == '0) begin
                    w_next = S_IDLE;
                end else if (w_tick) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                // A finished pass wins over a watchdog expiring on the same cycle.
                if (!r_first && w_done_all) begin
                    w_next = S_CHECK;
                end else if (w_tout_hit) begin
                    w_next = S_IDLE;
                end
            end
            S_CHECK: begin
                if (w_halt_now || !run) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_ARM;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // LVBL history for frame tick detection; idles high so reset never ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvbl <= 1'b1;
        end else begin
            r_lvbl <= LVBL;
        end
    end

    // Bank mask follows en while arming and freezes once the pass starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
        end else if (r_state == S_ARM) begin
            r_mask <= en;
        end
    end

    // Watchdog frame counter and first-RUN-cycle marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= 8'd0;
            r_first     <= 1'b0;
        end else if (r_state == S_START) begin
            r_frame_cnt <= 8'd0;
            r_first     <= 1'b1;
        end else if (r_state == S_RUN) begin
            r_first <= 1'b0;
            if (w_tick) begin
                r_frame_cnt <= w_frame_next;
            end
        end
    end

    // Sticky watchdog flag, set only when RUN actually gives up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if (r_state == S_RUN && w_next == S_IDLE) begin
            timeout <= 1'b1;
        end
    end

    // End-of-pass bookkeeping: error record, pass count, slow-mode toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_bank <= '0;
            pass_cnt <= 8'd0;
            slow     <= 1'b0;
        end else if (r_state == S_CHECK) begin
            bad_bank <= bad_bank | (bad & r_mask);
            slow     <= ~slow;
            if (pass_cnt != 8'hFF) begin
                pass_cnt <= pass_cnt + 8'd1;
            end
        end
    end

    // Outputs decoded from registers only, so no input reaches an output.
    assign start = (r_state == S_START) ? r_mask : '0;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_jtsdram_test_seq.sv
// tb_jtsdram_test_seq: directed scenarios followed by randomized traffic. A
// pass-level reference model predicts every output on every cycle; a few
// hand-computed values pin the model itself. Build with or without
// JTSDRAM_HALT_EN to match the RTL.
module tb_jtsdram_test_seq;

    localparam int         BANKS = 4;
    localparam logic [7:0] TOUT  = 8'd5;

    logic             clk  = 1'b0;
    logic             rst  = 1'b1;
    logic             LVBL = 1'b1;
    logic             run  = 1'b0;
    logic [BANKS-1:0] en   = '0;
    logic [BANKS-1:0] done = '0;
    logic [BANKS-1:0] bad  = '0;
    logic [BANKS-1:0] start;
    logic             slow;
    logic [BANKS-1:0] bad_bank;
    logic [7:0]       pass_cnt;
    logic             busy;
    logic             timeout;

    jtsdram_test_seq #(.BANKS(BANKS), .TOUT(TOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .LVBL     (LVBL),
        .run      (run),
        .en       (en),
        .done     (done),
        .bad      (bad),
        .start    (start),
        .slow     (slow),
        .bad_bank (bad_bank),
        .pass_cnt (pass_cnt),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Video timing: LVBL toggles every 1..4 cycles, so frames last 2..8 cycles.
    initial begin
        forever begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            LVBL = ~LVBL;
        end
    end

    // Checker emulation: a start pulse drops done, which returns after a
    // random delay. Stuck banks never finish. done_mode forces done directly.
    bit               done_mode  = 1'b1;
    logic [BANKS-1:0] done_force = '0;
    logic [BANKS-1:0] done_q     = '1;
    logic [BANKS-1:0] stuck      = '0;
    int               d_max      = 6;
    int               dly [BANKS];

    initial begin
        for (int i = 0; i < BANKS; i++) dly[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < BANKS; i++) begin
                if (start[i]) begin
                    dly[i]    = $urandom_range(1, d_max);
                    done_q[i] = 1'b0;
                end else if (dly[i] > 0) begin
                    dly[i]--;
                    if (dly[i] == 0) done_q[i] = 1'b1;
                end
            end
            done = done_mode ? done_force : (done_q & ~stuck);
        end
    end

    // ---------------- reference model ----------------
    typedef enum int {P_WAIT_RUN, P_WAIT_FRAME, P_LAUNCH, P_ACTIVE, P_RETIRE} phase_t;

    phase_t           m_phase    = P_WAIT_RUN;
    bit               m_lvbl     = 1'b1;
    logic [BANKS-1:0] m_mask     = '0;
    int               m_frames   = 0;
    int               m_age      = 0;
    bit               m_slow     = 1'b0;
    logic [BANKS-1:0] m_bad_bank = '0;
    int               m_pass     = 0;
    bit               m_timeout  = 1'b0;
    bit               m_halted   = 1'b0;

    initial begin
        bit tick;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase = P_WAIT_RUN; m_lvbl = 1'b1; m_mask = '0; m_frames = 0;
                m_age = 0; m_slow = 1'b0; m_bad_bank = '0; m_pass = 0;
                m_timeout = 1'b0; m_halted = 1'b0;
            end else begin
                tick   = m_lvbl && !LVBL;
                m_lvbl = LVBL;
                case (m_phase)
                    P_WAIT_RUN:
                        if (run && !m_timeout && !m_halted) m_phase = P_WAIT_FRAME;
                    P_WAIT_FRAME:
                        if (en == '0) m_phase = P_WAIT_RUN;
                        else if (tick) begin
                            m_mask  = en;
                            m_phase = P_LAUNCH;
                        end
                    P_LAUNCH: begin
                        m_frames = 0;
                        m_age    = 0;
                        m_phase  = P_ACTIVE;
                    end
                    P_ACTIVE: begin
                        m_age++;
                        if (m_age >= 2 && (done & m_mask) == m_mask) m_phase = P_RETIRE;
                        else if (tick) begin
                            m_frames++;
                            if (m_frames >= int'(TOUT)) begin
                                m_timeout = 1'b1;
                                m_phase   = P_WAIT_RUN;
                            end
                        end
                    end
                    P_RETIRE: begin
                        m_bad_bank = m_bad_bank | (bad & m_mask);
                        m_pass++;
                        m_slow  = !m_slow;
                        m_phase = run ? P_WAIT_FRAME : P_WAIT_RUN;
`ifdef JTSDRAM_HALT_EN
                        if ((bad & m_mask) != '0) begin
                            m_halted = 1'b1;
                            m_phase  = P_WAIT_RUN;
                        end
`endif
                    end
                    default: m_phase = P_WAIT_RUN;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("start",    start,    (m_phase == P_LAUNCH) ? m_mask : '0);
                check("slow",     slow,     m_slow);
                check("bad_bank", bad_bank, m_bad_bank);
                check("pass_cnt", pass_cnt, (m_pass > 255) ? 255 : m_pass);
                check("busy",     busy,     m_phase != P_WAIT_RUN);
                check("timeout",  timeout,  m_timeout);
            end
        end
    end

    // kind: 0 start pulse, 1 idle, 2 timeout, 3 pass_cnt >= target
    task automatic wait_for(input int kind, input int target, input int budget, input string name);
        int c = 0;
        bit ok;
        forever begin
            case (kind)
                0:       ok = (start != '0);
                1:       ok = !busy;
                2:       ok = timeout;
                default: ok = (int'(pass_cnt) >= target);
            endcase
            if (ok || c >= budget) break;
            @(negedge clk);
            c++;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: condition not met within %0d cycles", name, budget);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_start"},    start,    0);
        check({tag, "_slow"},     slow,     0);
        check({tag, "_bad_bank"}, bad_bank, 0);
        check({tag, "_pass_cnt"}, pass_cnt, 0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_timeout"},  timeout,  0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int seen;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        cmp_en = 1'b1;
        rst    = 1'b0;

        // Full pass with all banks through the checker emulation.
        done_mode = 1'b0; d_max = 6; en = 4'hF; run = 1'b1;
        wait_for(0, 0, 100, "first_start");
        check("first_start_val", start, 4'hF);
        wait_for(3, 1, 200, "pass1");
        check("pass1_cnt", pass_cnt, 1);
        check("pass1_slow", slow, 1);
        check("pass1_bad", bad_bank, 0);
        check("pass1_rearm", busy, 1);
        // Dropping run while armed still completes that pass.
        run = 1'b0;
        wait_for(1, 0, 200, "stop1");
        check("stop1_cnt", pass_cnt, 2);
        check("stop1_slow", slow, 0);

        // Partial mask: bank 1 never finishes and reports bad, both ignored.
        en = 4'b0101; stuck = 4'b0010; bad = 4'b0010; run = 1'b1;
        wait_for(3, 3, 200, "partial_pass");
        check("partial_bad", bad_bank, 0);
        run = 1'b0;
        wait_for(1, 0, 200, "stop2");
        check("stop2_cnt", pass_cnt, 4);
        stuck = '0;

        // Bank 2 reports a mismatch.
        en = 4'hF; bad = 4'b0100; run = 1'b1;
`ifdef JTSDRAM_HALT_EN
        wait_for(3, 5, 200, "halt_pass");
        repeat (40) @(negedge clk);
        check("halt_idle", busy, 0);
        check("halt_cnt", pass_cnt, 5);
        check("halt_bad", bad_bank, 4'b0100);
`else
        wait_for(3, 7, 300, "nohalt_pass");
        check("nohalt_bad", bad_bank, 4'b0100);
        check("nohalt_busy", busy, 1);
`endif
        run = 1'b0;
        wait_for(1, 0, 200, "stop3");
        pulse_rst();
        check("rst_clears_bad", bad_bank, 0);
        bad = '0;

        // Watchdog: done stuck low.
        done_mode = 1'b1; done_force = '0; run = 1'b1;
        wait_for(2, 0, 300, "timeout_set");
        check("timeout_idle", busy, 0);
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (start != '0 || busy) seen++;
        end
        check("no_start_after_timeout", seen, 0);
        check("timeout_sticky", timeout, 1);
        pulse_rst();
        check("rst_clears_timeout", timeout, 0);

        // done already high at START: first RUN cycle must not complete.
        done_force = 4'hF;
        wait_for(0, 0, 100, "stale_start");
        repeat (3) @(negedge clk);
        check("stale_done_ignored", pass_cnt, 0);
        @(negedge clk);
        check("stale_done_pass", pass_cnt, 1);

        // Reset in RUN after 200 passes, then saturation.
        wait_for(3, 200, 5000, "preload200");
        wait_for(0, 0, 100, "preload_start");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrun_rst");
        rst = 1'b0;
        wait_for(3, 255, 6000, "reach255");
        repeat (400) @(negedge clk);
        check("saturate", pass_cnt, 255);

        // Randomized traffic.
        done_mode = 1'b0;
        for (int ep = 0; ep < 40; ep++) begin
            if ($urandom_range(0, 3) == 0) pulse_rst();
            en    = 4'($urandom);
            bad   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
            stuck = ($urandom_range(0, 4) == 0) ? 4'($urandom) : '0;
            d_max = $urandom_range(1, 12);
            run   = 1'($urandom);
            repeat ($urandom_range(20, 120)) begin
                @(negedge clk);
                if ($urandom_range(0, 40) == 0) run = ~run;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
